// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL lock qualifier producing the 150 MHz domain reset
// Async-assert/sync-deassert reset output, released only after lock is stable for STABLE_CYCLES+HOLD_CYCLES.
module pll_reset_sequencer #(
    parameter int STABLE_CYCLES = 1024,
    parameter int HOLD_CYCLES   = 16,
    parameter int LOSS_WIDTH    = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  locked,
    output logic                  reset_out_n,
    output logic                  locked_sync,
    output logic [2:0]            state_dbg,
    output logic [LOSS_WIDTH-1:0] lock_loss_count
);

    localparam int MAX_CYCLES = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABILIZE = 3'd2,
        ST_HOLD      = 3'd3,
        ST_RUN       = 3'd4
    } state_e;

    logic rst_meta_q;
    logic rst_sync_q;
    logic rst_sync_n;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    // Every other flop in the block is reset by the synchronized copy.
    assign rst_sync_n = rst_sync_q;

    logic lock_meta_q;
    logic lock_sync_q;

    always_ff @(posedge clock or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
        end else begin
            lock_meta_q <= locked;
            lock_sync_q <= lock_meta_q;
        end
    end

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [LOSS_WIDTH-1:0] loss_q, loss_d;
    logic                  rst_out_q, rst_out_d;

    always_ff @(posedge clock or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state_q   <= ST_RESET;
            cnt_q     <= '0;
            loss_q    <= '0;
            rst_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            loss_q    <= loss_d;
            rst_out_q <= rst_out_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        loss_d    = loss_q;
        rst_out_d = 1'b0;
        case (state_q)
            ST_RESET: begin
                state_d = ST_WAIT_LOCK;
                cnt_d   = '0;
            end
            ST_WAIT_LOCK: begin
                if (lock_sync_q) begin
                    state_d = ST_STABILIZE;
                    cnt_d   = '0;
                end
            end
            ST_STABILIZE: begin
                if (!lock_sync_q) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (!lock_sync_q) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (!lock_sync_q) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                    if (loss_q != '1) begin
                        loss_d = loss_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_RESET;
                cnt_d   = '0;
            end
        endcase
        // Registered from the next state so the output flips on the same edge as the RUN transition.
        rst_out_d = (state_d == ST_RUN);
    end

    assign reset_out_n     = rst_out_q;
    assign locked_sync     = lock_sync_q;
    assign state_dbg       = state_q;
    assign lock_loss_count = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - bench for pll_reset_sequencer
// Two instances (8-bit and 2-bit loss counters) share stimulus and are compared against a run-length model.
module tb_pll_reset_sequencer;

    localparam int S = 8;
    localparam int H = 4;
    localparam int Q = S + H;

    logic clock   = 1'b0;
    logic reset_n = 1'b1;
    logic locked  = 1'b0;

    logic       rout1, ls1, rout2, ls2;
    logic [2:0] st1, st2;
    logic [7:0] loss1;
    logic [1:0] loss2;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clock = ~clock;

    pll_reset_sequencer #(.STABLE_CYCLES(S), .HOLD_CYCLES(H), .LOSS_WIDTH(8)) dut1 (
        .clock(clock), .reset_n(reset_n), .locked(locked),
        .reset_out_n(rout1), .locked_sync(ls1), .state_dbg(st1), .lock_loss_count(loss1)
    );

    pll_reset_sequencer #(.STABLE_CYCLES(S), .HOLD_CYCLES(H), .LOSS_WIDTH(2)) dut2 (
        .clock(clock), .reset_n(reset_n), .locked(locked),
        .reset_out_n(rout2), .locked_sync(ls2), .state_dbg(st2), .lock_loss_count(loss2)
    );

    // Model: edges since reset release, delayed lock samples, and length of the
    // current unbroken run of synchronized-high lock observed by the sequencer.
    int   m_rel, m_run, m_loss8, m_loss2;
    logic m_samp, m_lsync;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_rel = 0; m_run = 0; m_loss8 = 0; m_loss2 = 0;
            m_samp = 1'b0; m_lsync = 1'b0;
        end else begin
            m_rel = m_rel + 1;
            if (m_rel >= 4) begin
                if (m_lsync) begin
                    m_run = m_run + 1;
                end else begin
                    if (m_run > Q) begin
                        if (m_loss8 < 255) m_loss8 = m_loss8 + 1;
                        if (m_loss2 < 3)   m_loss2 = m_loss2 + 1;
                    end
                    m_run = 0;
                end
            end
            m_lsync = m_samp;
            m_samp  = (m_rel >= 3) ? locked : 1'b0;
        end
    end

    function automatic int exp_state();
        if (m_rel < 3)  return 0;
        if (m_run == 0) return 1;
        if (m_run <= S) return 2;
        if (m_run <= Q) return 3;
        return 4;
    endfunction

    function automatic int exp_rout();
        return (m_rel >= 3 && m_run > Q) ? 1 : 0;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (cmp_en) begin
            chk("state1", st1, exp_state());
            chk("rout1", rout1, exp_rout());
            chk("lsync1", ls1, m_lsync);
            chk("loss1", loss1, m_loss8);
            chk("state2", st2, exp_state());
            chk("rout2", rout2, exp_rout());
            chk("lsync2", ls2, m_lsync);
            chk("loss2", loss2, m_loss2);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        @(negedge clock);
    endtask

    int cyc;
    int hi_len, lo_len;
    int exp_l2 [4];
    int exp_l1 [4];

    initial begin
        exp_l2 = '{2, 3, 3, 3};
        exp_l1 = '{2, 3, 4, 5};
        #1 reset_n = 1'b0;
        locked = 1'b1;
        cmp_en = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_rout", rout1, 0);
        chk("reset_state", st1, 0);

        // Startup with locked constant high; this negedge follows edge 0.
        reset_n = 1'b1;
        step(2);  chk("A_e2_state", st1, 0);
        step(1);  chk("A_e3_state", st1, 1); chk("A_e3_model", exp_state(), 1);
        step(2);  chk("A_e5_state", st1, 2);
        step(7);  chk("A_e12_state", st1, 2);
        step(1);  chk("A_e13_state", st1, 3); chk("A_e13_model", exp_state(), 3);
        step(3);  chk("A_e16_rout", rout1, 0);
        step(1);  chk("A_e17_state", st1, 4); chk("A_e17_rout", rout1, 1);
        chk("A_e17_model", exp_rout(), 1);

        // One-cycle lock drop in RUN.
        locked = 1'b0;
        step(1);  chk("B_d1_rout", rout1, 1);
        locked = 1'b1;
        step(1);  chk("B_d2_rout", rout1, 1);
        step(1);  chk("B_d3_rout", rout1, 0); chk("B_d3_loss", loss1, 1); chk("B_d3_state", st1, 1);
        step(12); chk("B_d15_rout", rout1, 0);
        step(1);  chk("B_d16_rout", rout1, 1);

        // Repeated losses: 2-bit counter saturates at 3.
        for (int i = 0; i < 4; i++) begin
            locked = 1'b0;
            step(3);
            chk("C_loss2", loss2, exp_l2[i]);
            chk("C_loss1", loss1, exp_l1[i]);
            chk("C_rout", rout1, 0);
            locked = 1'b1;
            step(15);
            chk("C_rerun", rout2, 1);
        end
        chk("C_model_loss2", m_loss2, 3);

        // Reset asserted in RUN, between edges.
        reset_n = 1'b0;
        #1;
        chk("D_run_rout", rout1, 0); chk("D_run_state", st1, 0);
        chk("D_run_loss1", loss1, 0); chk("D_run_loss2", loss2, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            locked = ~locked;
            chk("D_toggle_state", st1, 0);
        end
        @(negedge clock);
        locked  = 1'b1;
        reset_n = 1'b1;
        step(14); chk("D_hold_state", st1, 3);
        #2 reset_n = 1'b0;
        #1;
        chk("D_hold_async_state", st1, 0); chk("D_hold_async_rout", rout1, 0);
        @(negedge clock);

        // Lock glitch during STABILIZE at cnt=5.
        reset_n = 1'b1;
        step(10); chk("E_e10_state", st1, 2);
        locked = 1'b0;
        step(3);  chk("E_e13_state", st1, 1); chk("E_e13_rout", rout1, 0); chk("E_e13_loss", loss1, 0);
        locked = 1'b1;
        step(14); chk("E_e27_state", st1, 3); chk("E_e27_rout", rout1, 0);
        step(1);  chk("E_e28_rout", rout1, 1); chk("E_e28_model", exp_rout(), 1);
        chk("E_e28_loss", loss1, 0);

        // Random lock waveform with changes placed between edges.
        cyc = 0;
        while (cyc < 10000) begin
            hi_len = $urandom_range(1, 40);
            lo_len = $urandom_range(1, 6);
            @(posedge clock); #($urandom_range(1, 8)); locked = 1'b1;
            repeat (hi_len - 1) @(posedge clock);
            @(posedge clock); #($urandom_range(1, 8)); locked = 1'b0;
            repeat (lo_len - 1) @(posedge clock);
            cyc = cyc + hi_len + lo_len;
        end
        @(negedge clock);
        @(negedge clock);
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
